// File: rtl/inta_sequencer_if.sv
// inta_sequencer_if: PIC-side strobe/data and vector-consumer handshake of the INTA sequencer.
interface inta_sequencer_if;
   logic       intr;
   logic       ie;
   logic [7:0] d;
   logic       vec_ready;
   logic       inta;
   logic [7:0] vector;
   logic       vec_valid;
   logic       busy;
   logic       cycle;
   modport master (input intr, ie, d, vec_ready, output inta, vector, vec_valid, busy, cycle);
   modport slave  (output intr, ie, d, vec_ready, input inta, vector, vec_valid, busy, cycle);
endinterface

// File: rtl/inta_sequencer.sv
// inta_sequencer: issues the two-pulse INTA acknowledge to a PIC and captures the vector
// from the data bus at the end of the second pulse, holding it until the consumer accepts.
module inta_sequencer #(
   parameter int PULSE_LEN = 2,
   parameter int GAP_LEN   = 2
) (
   input logic clk,
   input logic rst_n,
   inta_sequencer_if.master bus
);
   localparam logic [2:0] IDLE = 3'd0, P1_LOW = 3'd1, GAP = 3'd2, P2_LOW = 3'd3, WAIT_ACK = 3'd4;
   localparam logic [3:0] PL = 4'(PULSE_LEN - 1);
   localparam logic [3:0] GL = 4'(GAP_LEN - 1);
   logic [2:0] state, nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       s1, int_s;
   always_comb begin
      nxt     = state;
      cnt_nxt = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      case (state)
         IDLE:     if (int_s && bus.ie) begin nxt = P1_LOW; cnt_nxt = PL; end
         P1_LOW:   if (cnt == 4'd0) begin nxt = GAP; cnt_nxt = GL; end
         GAP:      if (cnt == 4'd0) begin nxt = P2_LOW; cnt_nxt = PL; end
         P2_LOW:   if (cnt == 4'd0) nxt = WAIT_ACK;
         WAIT_ACK: if (bus.vec_ready) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they change together with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         s1            <= 1'b0;
         int_s         <= 1'b0;
         bus.inta      <= 1'b1;
         bus.vector    <= 8'h00;
         bus.vec_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.cycle     <= 1'b0;
      end else begin
         state     <= nxt;
         cnt       <= cnt_nxt;
         s1        <= bus.intr;
         int_s     <= s1;
         bus.inta  <= !(nxt == P1_LOW || nxt == P2_LOW);
         bus.busy  <= nxt != IDLE;
         bus.cycle <= nxt == P2_LOW;
         if (state == P2_LOW && cnt == 4'd0) begin
            bus.vector    <= bus.d;
            bus.vec_valid <= 1'b1;
         end else if (state == WAIT_ACK && bus.vec_ready) begin
            bus.vec_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb_inta_sequencer: two instances (default timing and PULSE_LEN=1/GAP_LEN=3) checked against
// a timeline model that places each pulse by its offset from the sequence start edge.
module tb_inta_sequencer;
   logic clk = 1'b0, rst_n = 1'b0;
   logic intr = 1'b0, ie = 1'b0, vr = 1'b0;
   logic [7:0] d = 8'h00;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;

   inta_sequencer_if b0 ();
   inta_sequencer_if b1 ();
   assign b0.intr = intr; assign b0.ie = ie; assign b0.d = d; assign b0.vec_ready = vr;
   assign b1.intr = intr; assign b1.ie = ie; assign b1.d = d; assign b1.vec_ready = vr;
   inta_sequencer #(.PULSE_LEN(2), .GAP_LEN(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   inta_sequencer #(.PULSE_LEN(1), .GAP_LEN(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   int pl[2] = '{2, 1};
   int gl[2] = '{2, 3};
   bit act[2], wt[2], val[2];
   int rel[2];
   logic [7:0] vec[2];
   bit s1, s2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin act[n] = 0; wt[n] = 0; val[n] = 0; rel[n] = 0; vec[n] = 8'h00; end
      s1 = 0; s2 = 0;
   endtask

   // One rising edge: a started sequence is a fixed timeline of P low, G high, P low, then capture.
   task automatic model_step();
      for (int n = 0; n < 2; n++) begin
         if (act[n]) begin
            rel[n]++;
            if (rel[n] == 2 * pl[n] + gl[n]) begin act[n] = 0; wt[n] = 1; vec[n] = d; val[n] = 1; end
         end else if (wt[n]) begin
            if (vr) begin wt[n] = 0; val[n] = 0; end
         end else if (s2 && ie) begin
            act[n] = 1; rel[n] = 0;
         end
      end
      s2 = s1; s1 = intr;
   endtask

   function automatic bit in_p2(int n);
      return act[n] && rel[n] >= pl[n] + gl[n];
   endfunction

   function automatic bit in_gap(int n);
      return act[n] && rel[n] >= pl[n] && rel[n] < pl[n] + gl[n];
   endfunction

   task automatic chk_inst(input int n, input logic inta, input logic [7:0] vector, input logic vv,
                           input logic busy, input logic cyc_o);
      bit low;
      low = act[n] && (rel[n] < pl[n] || in_p2(n));
      chk($sformatf("inta%0d", n), inta, !low);
      chk($sformatf("vector%0d", n), vector, vec[n]);
      chk($sformatf("vec_valid%0d", n), vv, val[n]);
      chk($sformatf("busy%0d", n), busy, act[n] || wt[n]);
      chk($sformatf("cycle%0d", n), cyc_o, in_p2(n));
   endtask

   task automatic check_all();
      chk_inst(0, b0.inta, b0.vector, b0.vec_valid, b0.busy, b0.cycle);
      chk_inst(1, b1.inta, b1.vector, b1.vec_valid, b1.busy, b1.cycle);
   endtask

   task automatic cyc(input logic i, input logic e, input logic [7:0] dv, input logic r);
      intr = i; ie = e; d = dv; vr = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int k;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      // Default waveform: INT high from edge 0, vector A8, consumer always ready.
      for (int c = 0; c < 12; c++) cyc(1, 1, 8'hA8, 1);
      // IE low blocks starts; raising it starts a sequence.
      for (int c = 0; c < 20; c++) cyc(1, 0, 8'h3C, 1);
      for (int c = 0; c < 8; c++) cyc(1, 1, 8'h5A, 1);
      // Consumer stalls after capture, then accepts.
      for (int c = 0; c < 16; c++) cyc(1, 1, 8'hC3, 0);
      for (int c = 0; c < 10; c++) cyc(1, 1, 8'h77, 1);
      // Let everything drain, then drop INT in the gap.
      for (int c = 0; c < 12; c++) cyc(0, 1, 8'h11, 1);
      k = 0;
      while (!in_gap(0) && k < 30) begin cyc(1, 1, 8'hFF, 1); k++; end
      chk("reach_gap", k < 30, 1);
      for (int c = 0; c < 15; c++) cyc(0, 1, 8'hFF, 1);
      // Asynchronous reset in the second pulse.
      k = 0;
      while (!in_p2(0) && k < 30) begin cyc(1, 1, 8'h99, 1); k++; end
      chk("reach_p2", k < 30, 1);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) cyc(0, 1, 8'h99, 1);
      for (int c = 0; c < 12; c++) cyc(1, 1, 8'h42, 1);
      // Random traffic.
      for (int c = 0; c < 600; c++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
